// File: rtl/ps2_key_receiver_pkg.sv
// Shared constants, types and scan-code helpers for the PS/2 arrow-key receiver.
package ps2_key_receiver_pkg;

  localparam logic [1:0] KEY_NONE  = 2'b00;
  localparam logic [1:0] KEY_UP    = 2'b01;
  localparam logic [1:0] KEY_LEFT  = 2'b10;
  localparam logic [1:0] KEY_RIGHT = 2'b11;

  localparam logic [7:0] SCAN_EXT   = 8'hE0;
  localparam logic [7:0] SCAN_BRK   = 8'hF0;
  localparam logic [7:0] SCAN_UP    = 8'h75;
  localparam logic [7:0] SCAN_LEFT  = 8'h6B;
  localparam logic [7:0] SCAN_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SCAN_UP) || (code == SCAN_LEFT) || (code == SCAN_RIGHT);
  endfunction

  function automatic logic [1:0] scan_to_key(input logic [7:0] code);
    logic [1:0] key;
    case (code)
      SCAN_UP:    key = KEY_UP;
      SCAN_LEFT:  key = KEY_LEFT;
      SCAN_RIGHT: key = KEY_RIGHT;
      default:    key = KEY_NONE;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host framer: synchronizes and deglitches the keyboard lines,
// then assembles 11-bit frames into bytes with parity, framing and timeout checks.
module ps2_frame_rx
  import ps2_key_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 40000000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_byte_o,
  output logic       scan_valid_o,
  output logic       frame_error_o
);

  localparam longint unsigned TimeoutCycles =
      (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned ToW  = (TimeoutCycles > 64'd1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned FltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_s, data_s;
  logic [FltW-1:0] filt_cnt_q, filt_cnt_d;
  logic            clk_filt_q, clk_filt_d;
  logic            sample_edge;

  frame_state_e    state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]      scan_byte_q, scan_byte_d;
  logic            scan_valid_q, scan_valid_d;
  logic            frame_error_q, frame_error_d;

  // Idle-high lines, so the synchronizers reset to 1 to avoid a false edge at release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_comb begin
    filt_cnt_d = '0;
    clk_filt_d = clk_filt_q;
    if (clk_s != clk_filt_q) begin
      if (filt_cnt_q == FltW'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign sample_edge = clk_filt_q & ~clk_filt_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    to_cnt_d      = '0;
    scan_byte_d   = scan_byte_q;
    scan_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (sample_edge) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        StData: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = data_s;
          state_d  = StStop;
        end
        StStop: begin
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (data_s && (^{shift_q, parity_q})) begin
            scan_byte_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (to_cnt_q == ToW'(TimeoutCycles - 64'd1)) begin
        state_d       = StIdle;
        frame_error_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_cnt_q    <= '0;
      clk_filt_q    <= 1'b1;
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      scan_byte_q   <= '0;
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      filt_cnt_q    <= filt_cnt_d;
      clk_filt_q    <= clk_filt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      to_cnt_q      <= to_cnt_d;
      scan_byte_q   <= scan_byte_d;
      scan_valid_q  <= scan_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign scan_byte_o   = scan_byte_q;
  assign scan_valid_o  = scan_valid_q;
  assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver presenting the held arrow key as a 2-bit key_code,
// a drop-in replacement for the push-button key_code source.
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 40000000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] key_code,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_error
);

  logic [1:0] key_code_q, key_code_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  ps2_frame_rx #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_frame_rx (
    .clk_i        (clk),
    .rst_i        (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .scan_byte_o  (scan_byte),
    .scan_valid_o (scan_valid),
    .frame_error_o(frame_error)
  );

  always_comb begin
    key_code_d = key_code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;

    if (frame_error) begin
      // A corrupted frame may have been a prefix byte, so drop pending prefixes.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (scan_valid) begin
      if (scan_byte == SCAN_EXT) begin
        ext_d = 1'b1;
      end else if (scan_byte == SCAN_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q && is_arrow(scan_byte)) begin
          if (!brk_q) begin
            key_code_d = scan_to_key(scan_byte);
          end else if (scan_to_key(scan_byte) == key_code_q) begin
            key_code_d = KEY_NONE;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q <= KEY_NONE;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      key_code_q <= key_code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  assign key_code = key_code_q;

endmodule
